ifetch: RTL

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch -- instruction fetch unit with a circular instruction queue.
//
// Issues one word fetch at a time to the memory controller, buffers returned
// words together with their PC, and hands them to the decoder one per cycle
// when downstream is not stalled. A ROB redirect flushes the queue, retargets
// the PC, and causes any in-flight response to be dropped.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset (overrides rdy)
//   rdy          in   global ready; low freezes every register
//   mem_req      out  fetch request, held high until mem_done
//   mem_addr     out  address of the pending fetch
//   mem_done     in   one-cycle response pulse; mem_instr valid
//   mem_instr    in   fetched instruction word
//   stall_RS     in   downstream cannot accept an instruction this cycle
//   IF_success   out  one-cycle pulse: instr/fetch_pc valid
//   instr        out  delivered instruction
//   fetch_pc     out  PC of the delivered instruction
//   rob_jump     in   redirect/flush request
//   rob_jump_pc  in   new fetch PC, valid with rob_jump
// -----------------------------------------------------------------------------
module ifetch #(
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_instr,
  input  logic        stall_RS,
  output logic        IF_success,
  output logic [31:0] instr,
  output logic [31:0] fetch_pc,
  input  logic        rob_jump,
  input  logic [31:0] rob_jump_pc
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DISCARD   // response still owed by memory, but its data is stale
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               if_success_q, if_success_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               push, pop;

  logic [31:0] q_pc_mem    [QUEUE_DEPTH];
  logic [31:0] q_instr_mem [QUEUE_DEPTH];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    if_success_d = 1'b0;
    instr_d      = instr_q;
    fetch_pc_d   = fetch_pc_q;
    push         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Issue is gated on the current count; a response can add at most
        // one entry, so a slot is guaranteed when it arrives.
        if (!rob_jump && count_q != FULL_CNT) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
          if (!rob_jump) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end else if (rob_jump) begin
          // The request cannot be withdrawn; keep it up and swallow the reply.
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pop = !rob_jump && !stall_RS && count_q != '0;
    if (pop) begin
      if_success_d = 1'b1;
      instr_d      = q_instr_mem[head_q];
      fetch_pc_d   = q_pc_mem[head_q];
      head_d       = head_q + 1'b1;
    end
    if (push) begin
      tail_d = tail_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Redirect wins over push and pop in the same cycle.
    if (rob_jump) begin
      pc_d    = rob_jump_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the combinational block above uses blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      if_success_q <= 1'b0;
      instr_q      <= '0;
      fetch_pc_q   <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      if_success_q <= if_success_d;
      instr_q      <= instr_d;
      fetch_pc_q   <= fetch_pc_d;
    end
  end

  // NOTE: queue storage has no reset; count/head/tail define which entries
  // are valid, so clearing the array would only cost a reset tree.
  always_ff @(posedge clk) begin
    if (!rst && rdy && push) begin
      q_pc_mem[tail_q]    <= mem_addr_q;
      q_instr_mem[tail_q] <= mem_instr;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign IF_success = if_success_q;
  assign instr      = instr_q;
  assign fetch_pc   = fetch_pc_q;

endmodule
